// File: rtl/regbank_dump_reader.sv
// regbank_dump_reader
//   Read-side companion to the register-bank write sequencer. A start pulse
//   in IDLE walks register addresses 0..NUM_REGS-1 through one read port of
//   the bank. Each 32-bit value is captured and streamed out on a valid/ready
//   interface, tagged with its register index. The block never writes the
//   bank, so the write path is undisturbed.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   start      single-cycle dump request, sampled only in IDLE
//   rd_addr    bank read address (drives read_reg)
//   rd_data    bank read data, combinational from rd_addr
//   out_valid  out_data/out_idx hold a valid word
//   out_ready  consumer accepts the word on out_valid && out_ready
//   out_data   captured register value
//   out_idx    register index of out_data
//   busy       high from the cycle after start is accepted until done
//   done       single-cycle pulse after the last word is accepted
//
// Sequence per word: READ (one cycle, bank address stable, data captured at
// its closing edge) then SEND (held until the handshake). With out_ready
// held high this gives one word every two cycles.

module regbank_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              hs;

  assign hs = out_valid & out_ready;

  // All outputs are registered. rd_addr is loaded alongside idx so the bank
  // address is already stable at the start of each READ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          rd_addr <= '0;
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_READ;
          end
        end

        S_READ: begin
          out_data  <= rd_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            // Last-index check comes first so idx never wraps.
            if (idx == LAST_IDX) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              rd_addr <= '0;
              state   <= S_DONE;
            end else begin
              idx     <= idx + 1'b1;
              rd_addr <= idx + 1'b1;
              state   <= S_READ;
            end
          end
        end

        S_DONE: begin
          // start here is dropped; it is only sampled back in IDLE.
          done  <= 1'b0;
          idx   <= '0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: an 8x32 register bank model feeds rd_data;
// expected words are queued when each dump is launched and a negedge monitor
// pops and compares on every handshake.

module tb_regbank_dump_reader;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [N];

  const logic [DW-1:0] BASE [N] = '{32'h00000000, 32'h11111111, 32'h22222222,
                                    32'h33333333, 32'h44444444, 32'h55555555,
                                    32'h66666666, 32'h77777777};

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb [$];
  exp_t e;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regbank_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_word: got idx %0d data %h expected none", out_idx, out_data);
      end else begin
        e = sb.pop_front();
        check("word_idx", DW'(out_idx), DW'(e.idx));
        check("word_data", out_data, e.data);
      end
    end
    if (done) done_cnt++;
  end

  // Queue the 8 expected words; wr_idx >= 0 substitutes a value written
  // into the bank before that register is read.
  task automatic push_dump(input int wr_idx, input logic [DW-1:0] wr_val);
    for (int i = 0; i < N; i++)
      sb.push_back('{idx: AW'(i), data: (i == wr_idx) ? wr_val : BASE[i]});
  endtask

  // Returns just after the edge that samples start (E0).
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Wait at negedges for the READ cycle of a given address.
  task automatic wait_read(input logic [AW-1:0] a);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy && !out_valid && rd_addr == a) break;
    end
    vecs++;
    if (k == 100) begin
      errs++;
      $display("FAIL wait_read: got timeout expected READ at addr %0d", a);
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    vecs++;
    if (k == 200) begin
      errs++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < N; i++) regs[i] = BASE[i];

    // Reset defaults
    #2;
    check("rst_valid", DW'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_idx", DW'(out_idx), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_done", DW'(done), 0);
    check("rst_addr", DW'(rd_addr), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full dump with out_ready high: timing of valid, busy, done
    push_dump(-1, '0);
    d0 = done_cnt;
    pulse_start();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("first_busy", DW'(busy), 1);
        check("first_addr", DW'(rd_addr), 0);
      end
      if (n < 16) check("valid_pattern", DW'(out_valid), DW'(n % 2));
      check("done_timing", DW'(done), DW'(n == 16));
      if (n >= 16) check("busy_after", DW'(busy), 0);
    end
    check("full_sb_empty", DW'(sb.size()), 0);
    check("full_done_once", DW'(done_cnt - d0), 1);

    // Backpressure on word 3
    push_dump(-1, '0);
    pulse_start();
    wait_read(3);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", DW'(out_valid), 1);
      check("bp_data", out_data, 32'h33333333);
      check("bp_idx", DW'(out_idx), 3);
      check("bp_addr_held", DW'(rd_addr), 3);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done();
    check("bp_sb_empty", DW'(sb.size()), 0);

    // start while busy is ignored
    repeat (2) @(posedge clk);
    push_dump(-1, '0);
    d0 = done_cnt;
    pulse_start();
    wait_read(2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (4) begin
      @(negedge clk);
      check("ign_no_restart", DW'(busy), 0);
    end
    check("ign_sb_empty", DW'(sb.size()), 0);
    check("ign_done_once", DW'(done_cnt - d0), 1);

    // Reset in SEND at idx 5
    push_dump(-1, '0);
    pulse_start();
    wait_read(5);
    @(posedge clk); #1 out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", DW'(out_valid), 0);
    check("mid_rst_busy", DW'(busy), 0);
    check("mid_rst_addr", DW'(rd_addr), 0);
    check("mid_rst_idx", DW'(out_idx), 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_left", DW'(sb.size()), 3);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    push_dump(-1, '0);
    pulse_start();
    wait_done();
    check("post_rst_sb_empty", DW'(sb.size()), 0);

    // Concurrent write to r6 while idx 2 is being read
    repeat (2) @(posedge clk);
    push_dump(6, 32'hDEADBEEF);
    pulse_start();
    wait_read(2);
    regs[6] = 32'hDEADBEEF;
    wait_done();
    check("cw_sb_empty", DW'(sb.size()), 0);
    regs[6] = BASE[6];

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
